// File: rtl/branch_controller.sv
// Branch resolution sequencer for the ID stage: waits out RAW hazards, pulses the
// comparator ctrl for one cycle, then redirects the PC or releases the pipeline.
module branch_controller #(
   parameter int PC_W  = 16,
   parameter int OFF_W = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             brValid,
   input  logic [1:0]       brType,
   input  logic [3:0]       srcReg,
   input  logic [OFF_W-1:0] brOffset,
   input  logic [PC_W-1:0]  pcPlus2,
   input  logic             exWrEn,
   input  logic [3:0]       exWrReg,
   input  logic             memWrEn,
   input  logic [3:0]       memWrReg,
   input  logic             compOut,
   output logic [1:0]       compCtrl,
   output logic             stall,
   output logic             flush,
   output logic             pcSel,
   output logic [PC_W-1:0]  brTarget,
   output logic [PC_W-1:0]  brCount,
   output logic [PC_W-1:0]  takenCount
);

   typedef enum logic [2:0] {
      IDLE,
      WAIT_HAZ,
      RESOLVE,
      REDIRECT,
      RELEASE
   } state_t;

   state_t          state, state_nx;
   logic [1:0]      type_q;
   logic [3:0]      src_q;
   logic [3:0]      haz_src;
   logic            hazard;
   logic            accept;
   logic [PC_W-1:0] off_ext;
   logic [PC_W-1:0] target_nx;

   assign accept = brValid & (brType != 2'd0);

   // R15 is always checked alongside the source register; R0 gets no exemption.
   always_comb begin
      haz_src = (state == IDLE) ? srcReg : src_q;
      hazard  = (exWrEn  & ((exWrReg  == haz_src) | (exWrReg  == 4'd15))) |
                (memWrEn & ((memWrReg == haz_src) | (memWrReg == 4'd15)));
   end

   // Sign-extended word offset shifted into a byte offset, truncated to PC_W.
   always_comb begin
      off_ext = '0;
      for (int i = 1; i < PC_W; i++) begin
         int idx;
         idx        = (i - 1 < OFF_W) ? i - 1 : OFF_W - 1;
         off_ext[i] = brOffset[idx];
      end
      target_nx = pcPlus2 + off_ext;
   end

   // NOTE: every output and next-state value gets a default first, so no path
   // through the case can leave one unassigned and infer a latch.
   always_comb begin
      state_nx = state;
      compCtrl = 2'd0;
      stall    = 1'b0;
      flush    = 1'b0;
      pcSel    = 1'b0;
      unique case (state)
         IDLE: begin
            // Gated by rst so nothing is driven while reset is held.
            stall = rst & accept;
            if (accept) state_nx = hazard ? WAIT_HAZ : RESOLVE;
         end
         WAIT_HAZ: begin
            stall = 1'b1;
            if (!hazard) state_nx = RESOLVE;
         end
         RESOLVE: begin
            stall    = 1'b1;
            compCtrl = type_q;
            state_nx = compOut ? REDIRECT : RELEASE;
         end
         REDIRECT: begin
            flush    = 1'b1;
            pcSel    = 1'b1;
            state_nx = IDLE;
         end
         RELEASE: state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   // NOTE: all sequential state uses non-blocking assignments so every register
   // samples the pre-edge values regardless of statement order.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state      <= IDLE;
         type_q     <= 2'd0;
         src_q      <= 4'd0;
         brTarget   <= '0;
         brCount    <= '0;
         takenCount <= '0;
      end else begin
         state <= state_nx;
         if (state == IDLE && accept) begin
            type_q   <= brType;
            src_q    <= srcReg;
            brTarget <= target_nx;
         end
         if (state == RESOLVE) begin
            if (!(&brCount)) brCount <= brCount + PC_W'(1);
            if (compOut && !(&takenCount)) takenCount <= takenCount + PC_W'(1);
         end
      end
   end

endmodule

// File: tb/tb_branch_controller.sv
// Scoreboard bench for branch_controller: stimulus pushes hand-computed per-cycle
// expectations, a negedge monitor pops and compares them against the DUT.
module tb_branch_controller;

   logic        clk = 1'b0;
   logic        rst;
   logic        brValid;
   logic [1:0]  brType;
   logic [3:0]  srcReg;
   logic [7:0]  brOffset;
   logic [15:0] pcPlus2;
   logic        exWrEn;
   logic [3:0]  exWrReg;
   logic        memWrEn;
   logic [3:0]  memWrReg;
   logic        compOut;
   logic [1:0]  compCtrl;
   logic        stall, flush, pcSel;
   logic [15:0] brTarget, brCount, takenCount;

   // Narrow-counter instance sharing the same stimulus, used for saturation.
   logic [1:0]  s_compCtrl;
   logic        s_stall, s_flush, s_pcSel;
   logic [3:0]  s_brTarget, s_brCount, s_takenCount;

   always #5 clk = ~clk;

   branch_controller #(.PC_W(16), .OFF_W(8)) dut (
      .clk(clk), .rst(rst), .brValid(brValid), .brType(brType), .srcReg(srcReg),
      .brOffset(brOffset), .pcPlus2(pcPlus2), .exWrEn(exWrEn), .exWrReg(exWrReg),
      .memWrEn(memWrEn), .memWrReg(memWrReg), .compOut(compOut),
      .compCtrl(compCtrl), .stall(stall), .flush(flush), .pcSel(pcSel),
      .brTarget(brTarget), .brCount(brCount), .takenCount(takenCount)
   );

   branch_controller #(.PC_W(4), .OFF_W(8)) dut_s (
      .clk(clk), .rst(rst), .brValid(brValid), .brType(brType), .srcReg(srcReg),
      .brOffset(brOffset), .pcPlus2(pcPlus2[3:0]), .exWrEn(exWrEn), .exWrReg(exWrReg),
      .memWrEn(memWrEn), .memWrReg(memWrReg), .compOut(compOut),
      .compCtrl(s_compCtrl), .stall(s_stall), .flush(s_flush), .pcSel(s_pcSel),
      .brTarget(s_brTarget), .brCount(s_brCount), .takenCount(s_takenCount)
   );

   typedef struct {
      string       nm;
      logic        st, fl, ps;
      logic [1:0]  cc;
      logic [15:0] tg, bc, tc;
      logic [3:0]  sbc, stc;
   } exp_t;

   exp_t        sb[$];
   exp_t        e;
   int          n_tests = 0;
   int          n_fail  = 0;
   logic [15:0] exp_tg, exp_bc, exp_tc;

   always @(negedge clk) begin
      if (sb.size() > 0) begin
         e = sb.pop_front();
         n_tests++;
         if (stall !== e.st || flush !== e.fl || pcSel !== e.ps || compCtrl !== e.cc ||
             brTarget !== e.tg || brCount !== e.bc || takenCount !== e.tc ||
             s_brCount !== e.sbc || s_takenCount !== e.stc) begin
            n_fail++;
            $display("FAIL %s: got st=%b fl=%b ps=%b cc=%0d tg=%h bc=%h tc=%h sbc=%h stc=%h | exp st=%b fl=%b ps=%b cc=%0d tg=%h bc=%h tc=%h sbc=%h stc=%h",
                     e.nm, stall, flush, pcSel, compCtrl, brTarget, brCount, takenCount,
                     s_brCount, s_takenCount, e.st, e.fl, e.ps, e.cc, e.tg, e.bc, e.tc,
                     e.sbc, e.stc);
         end
      end
   end

   task automatic cyc(input string nm, input bit v, input bit [1:0] t, input bit [3:0] s,
                      input bit [7:0] off, input bit [15:0] pc, input bit cmp,
                      input bit exe, input bit [3:0] exr, input bit me, input bit [3:0] mer,
                      input bit e_st, input bit e_fl, input bit e_ps, input bit [1:0] e_cc);
      exp_t x;
      brValid  = v;   brType  = t;   srcReg   = s;   brOffset = off; pcPlus2 = pc;
      compOut  = cmp; exWrEn  = exe; exWrReg  = exr; memWrEn  = me;  memWrReg = mer;
      x.nm  = nm;   x.st = e_st; x.fl = e_fl; x.ps = e_ps; x.cc = e_cc;
      x.tg  = exp_tg; x.bc = exp_bc; x.tc = exp_tc;
      x.sbc = (exp_bc > 16'd15) ? 4'hF : exp_bc[3:0];
      x.stc = (exp_tc > 16'd15) ? 4'hF : exp_tc[3:0];
      sb.push_back(x);
      @(posedge clk);
      #1;
   endtask

   task automatic idle(input string nm);
      cyc(nm, 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, required completion");
      $fatal(1, "watchdog");
   end

   initial begin
      rst = 1'b0;
      exp_tg = 16'h0000; exp_bc = 16'h0000; exp_tc = 16'h0000;
      @(posedge clk);
      #1;

      // Reset held with a branch offered: everything stays 0.
      for (int i = 0; i < 3; i++)
         cyc("rst_hold", 1, 3, 1, 8'h04, 16'h0010, 1, 0, 0, 0, 0, 0, 0, 0, 0);

      // BEQ taken, no hazard: target 0x0010 + 8 = 0x0018.
      rst = 1'b1;
      cyc("beq_c1", 1, 3, 1, 8'h04, 16'h0010, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      exp_tg = 16'h0018;
      cyc("beq_c2", 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 3);
      exp_bc = 16'd1; exp_tc = 16'd1;
      cyc("beq_c3", 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle("beq_idle");

      // BLT not taken, backward offset: 0x0002 - 4 = 0xFFFE; compOut=1 in RELEASE ignored.
      cyc("blt_c1", 1, 1, 2, 8'hFE, 16'h0002, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      exp_tg = 16'hFFFE;
      cyc("blt_c2", 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 1);
      exp_bc = 16'd2;
      cyc("blt_c3", 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      idle("blt_idle");

      // Hazard: EX writes R5 in cycle 1, MEM writes R15 in cycle 2; live inputs ignored.
      cyc("haz_c1", 1, 2, 5, 8'h7F, 16'h0100, 0, 1, 5, 0, 0, 1, 0, 0, 0);
      exp_tg = 16'h01FE;
      cyc("haz_c2", 1, 3, 0, 8'h00, 16'h0000, 1, 0, 0, 1, 15, 1, 0, 0, 0);
      cyc("haz_c3", 1, 3, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("haz_c4", 1, 3, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 2);
      exp_bc = 16'd3; exp_tc = 16'd2;
      cyc("haz_c5", 1, 3, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      idle("haz_idle");

      // R0 is not exempt: MEM writing R0 stalls a branch on R0.
      cyc("r0_c1", 1, 3, 0, 8'h01, 16'h0040, 0, 0, 0, 1, 0, 1, 0, 0, 0);
      exp_tg = 16'h0042;
      cyc("r0_c2", 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("r0_c3", 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 1, 0, 0, 3);
      exp_bc = 16'd4;
      cyc("r0_c4", 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Non-branch with brValid=1: no stall.
      cyc("nobr_a", 1, 0, 3, 8'h10, 16'h0200, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("nobr_b", 1, 0, 3, 8'h10, 16'h0200, 0, 0, 0, 0, 0, 0, 0, 0, 0);

      // Reset mid-branch in WAIT_HAZ: abandoned with no redirect.
      cyc("rmid_c1", 1, 3, 7, 8'h02, 16'h0300, 0, 1, 7, 0, 0, 1, 0, 0, 0);
      exp_tg = 16'h0304;
      cyc("rmid_c2", 0, 0, 0, 8'h00, 16'h0000, 0, 1, 7, 0, 0, 1, 0, 0, 0);
      rst = 1'b0;
      exp_tg = 16'h0000; exp_bc = 16'h0000; exp_tc = 16'h0000;
      cyc("rmid_rst", 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("rmid_rst2", 1, 3, 7, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 0, 0, 0, 0);
      rst = 1'b1;
      idle("rmid_after1");
      idle("rmid_after2");

      // Saturation: 17 taken branches; narrow counters reach 0xE after 14, then stick at 0xF.
      for (int i = 0; i < 17; i++) begin
         cyc("sat_c1", 1, 3, 1, 8'h01, 16'h0020, 0, 0, 0, 0, 0, 1, 0, 0, 0);
         exp_tg = 16'h0022;
         cyc("sat_c2", 0, 0, 0, 8'h00, 16'h0000, 1, 0, 0, 0, 0, 1, 0, 0, 3);
         exp_bc = exp_bc + 16'd1; exp_tc = exp_tc + 16'd1;
         cyc("sat_c3", 0, 0, 0, 8'h00, 16'h0000, 0, 0, 0, 0, 0, 0, 1, 1, 0);
      end
      idle("sat_final");

      if (sb.size() != 0) begin
         n_tests++;
         n_fail++;
         $display("FAIL drain: got %0d pending, required 0", sb.size());
      end
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule

// File: doc/branch_controller.md
Name: branch_controller

Overview:
- Sequences branch resolution for the 16-bit pipelined CPU.
- Detects read-after-write hazards on the branch source register and on R15, and stalls until both are safe to read.
- Drives the combinational BLT/BGT/BEQ comparator's ctrl input for exactly one cycle, samples its result, then either redirects the PC with an IF/ID flush or releases the pipeline.
- Keeps saturating branch/taken statistics counters; sits in the ID stage beside the register file and comparator.

Parameters:
PC_W, 16, width of PC, branch target and statistics counters
OFF_W, 8, width of signed branch word offset in the instruction

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
brValid  in  1  ID stage holds a branch instruction
brType  in  2  1=BLT, 2=BGT, 3=BEQ, 0=not a branch
srcReg  in  4  register index read as readData1
brOffset  in  OFF_W  signed word offset
pcPlus2  in  PC_W  address of branch + 2
exWrEn  in  1  EX stage will write a register
exWrReg  in  4  EX stage destination
memWrEn  in  1  MEM stage will write a register
memWrReg  in  4  MEM stage destination
compOut  in  1  comparator result
compCtrl  out  2  comparator ctrl
stall  out  1  hold PC and IF/ID, bubble into EX
flush  out  1  squash IF/ID contents
pcSel  out  1  1 = load PC from brTarget
brTarget  out  PC_W  computed branch target
brCount  out  PC_W  branches resolved (saturating)
takenCount  out  PC_W  branches taken (saturating)

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE; compCtrl=0, stall=0, flush=0, pcSel=0, brTarget=0, brCount=0, takenCount=0; latched fields cleared. Reset mid-branch abandons it without a redirect.
- Hazard (combinational): (exWrEn & (exWrReg==S | exWrReg==15)) | (memWrEn & (memWrReg==S | memWrReg==15)).
  - S is srcReg in IDLE and the latched source register in other states.
  - All 16 registers are treated alike; R0 is not exempt.
- States IDLE, WAIT_HAZ, RESOLVE, REDIRECT, RELEASE.
- IDLE:
  - brValid=1 and brType!=0: stall=1 combinationally in that cycle.
  - Latch brType, srcReg and brTarget = pcPlus2 + (sign-extended brOffset << 1), truncated mod 2^PC_W.
  - Next state: WAIT_HAZ if hazard, else RESOLVE.
  - brValid=1 with brType=0, or brValid=0: no action, stall=0.
- WAIT_HAZ: stall=1, compCtrl=0. Move to RESOLVE in the first cycle hazard=0; stay indefinitely otherwise.
- RESOLVE:
  - stall=1, compCtrl=latched type in this cycle only.
  - compOut is sampled at the clock edge; brCount increments.
  - compOut=1: takenCount increments, next state REDIRECT.
  - compOut=0: next state RELEASE.
- REDIRECT: pcSel=1, flush=1, stall=0, brTarget stable; one cycle, then IDLE.
- RELEASE: stall=0, pcSel=0, flush=0; one cycle, lets the branch leave ID; then IDLE.
- compCtrl is 0 in every state except RESOLVE. The comparator holds its prior output when ctrl=0, so compOut is ignored outside RESOLVE.
- Inputs brValid, brType, srcReg, brOffset and pcPlus2 are ignored outside IDLE; the latched copies are used.
- Counters saturate at all-ones; no wrap.
- Latency:
  - Not taken, no hazard: 2 stall cycles, release in cycle 3.
  - Taken, no hazard: 2 stall cycles, redirect in cycle 3.
  - Each hazard cycle adds 1 stall cycle.
- flush and pcSel are only ever asserted together, for exactly one cycle per taken branch.

Test Plan:
- Reset: hold rst=0 with brValid=1, brType=3 -> all outputs 0 throughout; release rst -> branch accepted the next cycle, stall=1.
- BEQ taken, no hazard: pcPlus2=0x0010, brOffset=0x04, compOut=1 in RESOLVE -> stall 1,1,0; compCtrl=3 in cycle 2 only; cycle 3 pcSel=1, flush=1, brTarget=0x0018; brCount=1, takenCount=1.
- BLT not taken, backward offset: pcPlus2=0x0002, brOffset=0xFE, compOut=0 -> brTarget=0xFFFE (wraps); cycle 3 stall=0, pcSel=0, flush=0; brCount=1, takenCount=0.
- Hazard: srcReg=5, exWrEn=1, exWrReg=5 for 1 cycle, then memWrEn=1, memWrReg=15 for 1 cycle -> WAIT_HAZ for 2 cycles; compCtrl=0 in both; RESOLVE in cycle 4; total stall 4 cycles.
- Non-branch and reset mid-op:
  - brValid=1, brType=0 -> no stall.
  - Branch accepted, then rst=0 during WAIT_HAZ -> stall drops immediately; no pcSel/flush ever asserted.
- Saturation: preload both counters to 0xFFFE, run 3 taken branches -> both read 0xFFFF afterwards.
